// File: rtl/lsu_mem_master.sv
// Load/store initiator: turns one pipeline lw/lh/lb/sw/sh/sb into a
// word-aligned req/ack memory transaction and returns extended load data.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_valid_i, load_i,      pipeline request: op, size (00 b / 01 h /
//   store_i, size_i,          10 w / 11 illegal), zero-extend flag,
//   unsigned_i, addr_i,       byte address and right-justified
//   wdata_i                   store data
//   stall_o                   pipeline must hold
//   rdata_o, rdata_valid_o    extended load data, one-cycle valid pulse
//   done_o, err_o             completion / error one-cycle pulses
//   mem_req_o, mem_we_o,      memory request, write enable,
//   mem_addr_o, mem_be_o,     word address, byte enables,
//   mem_wdata_o               lane-replicated store data
//   mem_ack_i, mem_rdata_i    memory completion and read word
module lsu_mem_master #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        load_i,
    input  logic        store_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        done_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lane_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic             tout_q;
    logic             bad_q;

    logic             aligned;
    logic             accept;
    logic             timeout;
    logic [3:0]       be_nxt;
    logic [31:0]      wdata_nxt;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      ext;

    // Request qualification
    always_comb begin
        aligned = 1'b1;
        case (size_i)
            2'b01:   aligned = ~addr_i[0];
            2'b10:   aligned = (addr_i[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign accept = req_valid_i && (load_i ^ store_i) &&
                    (size_i != 2'b11) && aligned;

    assign timeout = (cnt == CNT_LAST) && !mem_ack_i;

    // Byte enables and lane-replicated store data
    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = wdata_i;
        case (size_i)
            2'b00: begin
                be_nxt    = 4'b0001 << addr_i[1:0];
                wdata_nxt = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_nxt    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{wdata_i[15:0]}};
            end
            default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = wdata_i;
            end
        endcase
    end

    // Load lane extraction from the word returned with ack
    always_comb begin
        byte_sel = mem_rdata_i[7:0];
        case (lane_q)
            2'd1:    byte_sel = mem_rdata_i[15:8];
            2'd2:    byte_sel = mem_rdata_i[23:16];
            2'd3:    byte_sel = mem_rdata_i[31:24];
            default: byte_sel = mem_rdata_i[7:0];
        endcase
        half_sel = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (size_q)
            2'b00:   ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   ext = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: ext = mem_rdata_i;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (mem_ack_i || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        stall_o       = 1'b0;
        done_o        = 1'b0;
        rdata_valid_o = 1'b0;
        err_o         = bad_q;
        case (state)
            IDLE: stall_o = accept;
            WAIT: stall_o = 1'b1;
            DONE: begin
                done_o        = 1'b1;
                rdata_valid_o = !mem_we_o && !tout_q;
                err_o         = tout_q;
            end
            default: stall_o = 1'b0;
        endcase
    end

    // Transaction datapath
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
            lane_q      <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            cnt         <= '0;
            tout_q      <= 1'b0;
            bad_q       <= 1'b0;
            rdata_o     <= '0;
        end else begin
            // A rejected request reports err_o one cycle later
            bad_q <= (state == IDLE) && req_valid_i && !accept;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= store_i;
                        mem_addr_o  <= {addr_i[31:2], 2'b00};
                        mem_be_o    <= be_nxt;
                        mem_wdata_o <= wdata_nxt;
                        lane_q      <= addr_i[1:0];
                        size_q      <= size_i;
                        uns_q       <= unsigned_i;
                        cnt         <= '0;
                        tout_q      <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        if (!mem_we_o) rdata_o <= ext;
                    end else if (timeout) begin
                        mem_req_o <= 1'b0;
                        tout_q    <= 1'b1;
                        rdata_o   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
